// File: rtl/line_ring_ctrl_pkg.sv
// Shared constants and display FSM state type for the line-buffer ring
// and its neighbours (line mux, fill engine).
package line_ring_ctrl_pkg;

    localparam int SELECT_WIDTH = 4;
    localparam int LINES        = 15;
    localparam int ADDR_WIDTH   = 10;
    localparam int H_ACTIVE     = 640;

    typedef enum logic {
        DISP_IDLE   = 1'b0,
        DISP_ACTIVE = 1'b1
    } disp_state_e;

endpackage

// File: rtl/line_ring_ctrl_ring_ptr.sv
// Modulo-LINES wrapping pointer with advance enable; used for both the
// fill and display positions in the buffer ring.
module ring_ptr #(
    parameter int WIDTH = 4,
    parameter int LINES = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LINES - 1);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/line_ring_ctrl.sv
// Line-buffer ring sequencer: hands free buffers to the fill engine and
// steps the display through filled buffers in step with VGA strobes.
module line_ring_ctrl #(
    parameter int SELECT_WIDTH = line_ring_ctrl_pkg::SELECT_WIDTH,
    parameter int LINES        = line_ring_ctrl_pkg::LINES,
    parameter int ADDR_WIDTH   = line_ring_ctrl_pkg::ADDR_WIDTH,
    parameter int H_ACTIVE     = line_ring_ctrl_pkg::H_ACTIVE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_line_start,
    input  logic                    i_pixel_en,
    input  logic                    i_fill_done,
    output logic                    o_fill_req,
    output logic [SELECT_WIDTH-1:0] o_fill_sel,
    output logic [SELECT_WIDTH-1:0] o_select,
    output logic [ADDR_WIDTH-1:0]   o_rd_addr,
    output logic                    o_underrun
);

    import line_ring_ctrl_pkg::*;

    localparam int                    CW        = SELECT_WIDTH + 1;
    localparam logic [CW-1:0]         LINES_C   = CW'(LINES);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_ACTIVE - 1);

    disp_state_e             state_q, state_d;
    logic                    own_q, own_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    underrun_q, underrun_d;
    logic [CW-1:0]           count_q, count_d;

    logic [SELECT_WIDTH-1:0] fill_ptr;
    logic [SELECT_WIDTH-1:0] disp_ptr;
    logic                    fill_adv;
    logic                    rel_buf;

    assign fill_adv = i_fill_done && (count_q < LINES_C);

    ring_ptr #(.WIDTH(SELECT_WIDTH), .LINES(LINES)) u_fill_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (fill_adv),
        .ptr   (fill_ptr)
    );

    ring_ptr #(.WIDTH(SELECT_WIDTH), .LINES(LINES)) u_disp_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (rel_buf),
        .ptr   (disp_ptr)
    );

    // A line start always wins: it aborts any line in progress without release.
    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        underrun_d = underrun_q;
        rel_buf    = 1'b0;
        if (i_line_start) begin
            addr_d  = '0;
            state_d = DISP_ACTIVE;
            if (count_q != '0) begin
                sel_d = disp_ptr;
                own_d = 1'b1;
            end else begin
                underrun_d = 1'b1;
                own_d      = 1'b0;
            end
        end else if (state_q == DISP_ACTIVE && i_pixel_en) begin
            if (addr_q == LAST_ADDR) begin
                state_d = DISP_IDLE;
                rel_buf = own_q;
            end else begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({fill_adv, rel_buf})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= DISP_IDLE;
            own_q      <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            underrun_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            underrun_q <= underrun_d;
            count_q    <= count_d;
        end
    end

    assign o_fill_req = (count_q < LINES_C);
    assign o_fill_sel = fill_ptr;
    assign o_select   = sel_q;
    assign o_rd_addr  = addr_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_line_ring_ctrl.sv
// Bench for line_ring_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_line_ring_ctrl;

    localparam int SW    = 4;
    localparam int LINES = 15;
    localparam int AW    = 10;
    localparam int H     = 640;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_line_start = 1'b0;
    logic          i_pixel_en = 1'b0;
    logic          i_fill_done = 1'b0;
    logic          o_fill_req;
    logic [SW-1:0] o_fill_sel;
    logic [SW-1:0] o_select;
    logic [AW-1:0] o_rd_addr;
    logic          o_underrun;

    line_ring_ctrl #(
        .SELECT_WIDTH (SW),
        .LINES        (LINES),
        .ADDR_WIDTH   (AW),
        .H_ACTIVE     (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_line_start (i_line_start),
        .i_pixel_en   (i_pixel_en),
        .i_fill_done  (i_fill_done),
        .o_fill_req   (o_fill_req),
        .o_fill_sel   (o_fill_sel),
        .o_select     (o_select),
        .o_rd_addr    (o_rd_addr),
        .o_underrun   (o_underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of filled buffer indices, oldest first; its head is the
    // next buffer to show and its length is the number of pending lines.
    int m_filled[$];
    int m_fill_idx;
    bit m_active, m_own, m_underrun, m_rel, m_acc;
    int m_sel, m_addr;
    bit chk_en = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_filled.delete();
                m_fill_idx = 0;
                m_active   = 1'b0;
                m_own      = 1'b0;
                m_underrun = 1'b0;
                m_sel      = 0;
                m_addr     = 0;
            end else begin
                m_rel = 1'b0;
                m_acc = i_fill_done && (m_filled.size() < LINES);
                if (i_line_start) begin
                    m_addr   = 0;
                    m_active = 1'b1;
                    if (m_filled.size() > 0) begin
                        m_sel = m_filled[0];
                        m_own = 1'b1;
                    end else begin
                        m_underrun = 1'b1;
                        m_own      = 1'b0;
                    end
                end else if (m_active && i_pixel_en) begin
                    if (m_addr == H - 1) begin
                        m_active = 1'b0;
                        m_rel    = m_own;
                    end else begin
                        m_addr = m_addr + 1;
                    end
                end
                if (m_rel) void'(m_filled.pop_front());
                if (m_acc) begin
                    m_filled.push_back(m_fill_idx);
                    m_fill_idx = (m_fill_idx + 1) % LINES;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_fill_req", o_fill_req, (m_filled.size() < LINES) ? 1 : 0);
                chk("model_fill_sel", o_fill_sel, m_fill_idx);
                chk("model_select", o_select, m_sel);
                chk("model_rd_addr", o_rd_addr, m_addr);
                chk("model_underrun", o_underrun, m_underrun);
            end
        end
    end

    task automatic step(input bit ls, input bit pe, input bit fd);
        i_line_start = ls;
        i_pixel_en   = pe;
        i_fill_done  = fd;
        @(negedge clk);
        i_line_start = 1'b0;
        i_pixel_en   = 1'b0;
        i_fill_done  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic full_line();
        step(1'b1, 1'b0, 1'b0);
        repeat (H) step(1'b0, 1'b1, 1'b0);
    endtask

    int fd_per_1024;

    initial begin
        do_reset();
        chk_en = 1'b1;

        // Reset state, then three fills.
        chk("rst_fill_req", o_fill_req, 1);
        chk("rst_fill_sel", o_fill_sel, 0);
        chk("rst_select", o_select, 0);
        chk("rst_rd_addr", o_rd_addr, 0);
        chk("rst_underrun", o_underrun, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("fill_sel_step", o_fill_sel, i + 1);
        end
        chk("three_fill_req", o_fill_req, 1);
        chk("three_underrun", o_underrun, 0);

        // One full line from buffer 0; address runs 0..639 then holds.
        step(1'b1, 1'b0, 1'b0);
        chk("line_select", o_select, 0);
        for (int k = 0; k < H; k++) begin
            chk("line_addr", o_rd_addr, k < H - 1 ? k : H - 1);
            step(1'b0, 1'b1, 1'b0);
        end
        chk("line_addr_hold", o_rd_addr, H - 1);
        // Two lines remain pending, so exactly 13 more fills reach full.
        for (int i = 0; i < 13; i++) begin
            chk("refill_req", o_fill_req, 1);
            step(1'b0, 1'b0, 1'b1);
        end
        chk("refill_full", o_fill_req, 0);
        chk("refill_sel", o_fill_sel, 1);

        // Fifteen fills with no display, then an ignored sixteenth.
        do_reset();
        repeat (LINES) step(1'b0, 1'b0, 1'b1);
        chk("full_req", o_fill_req, 0);
        chk("full_sel_wrap", o_fill_sel, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("extra_fill_sel", o_fill_sel, 0);
        chk("extra_fill_req", o_fill_req, 0);

        // Underrun: the previous buffer repeats and nothing is released.
        do_reset();
        repeat (2) step(1'b0, 1'b0, 1'b1);
        full_line();
        full_line();
        chk("pre_underrun", o_underrun, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("underrun_set", o_underrun, 1);
        chk("underrun_select_hold", o_select, 1);
        repeat (H) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("after_underrun_select", o_select, 2);
        chk("underrun_sticky", o_underrun, 1);

        // Fill completing on the same cycle as the last pixel.
        do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        repeat (H - 1) step(1'b0, 1'b1, 1'b0);
        chk("last_pixel_addr", o_rd_addr, H - 1);
        step(1'b0, 1'b1, 1'b1);
        chk("coinc_fill_sel", o_fill_sel, 2);
        chk("coinc_fill_req", o_fill_req, 1);
        step(1'b1, 1'b0, 1'b0);
        chk("coinc_next_select", o_select, 1);
        chk("coinc_no_underrun", o_underrun, 0);

        // Asynchronous reset in the middle of a line.
        do_reset();
        repeat (3) step(1'b0, 1'b0, 1'b1);
        full_line();
        step(1'b1, 1'b0, 1'b0);
        repeat (300) step(1'b0, 1'b1, 1'b0);
        chk("mid_select", o_select, 1);
        chk("mid_addr", o_rd_addr, 300);
        #2 reset = 1'b1;
        #1;
        chk("async_select", o_select, 0);
        chk("async_addr", o_rd_addr, 0);
        chk("async_fill_sel", o_fill_sel, 0);
        chk("async_underrun", o_underrun, 0);
        chk("async_fill_req", o_fill_req, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_fill_req", o_fill_req, 1);

        // Randomized traffic in segments that fill fast, drain, and balance.
        for (int seg = 0; seg < 6; seg++) begin
            case (seg)
                0: fd_per_1024 = 40;
                1: fd_per_1024 = 0;
                2: fd_per_1024 = 2;
                3: fd_per_1024 = 200;
                4: fd_per_1024 = 1;
                default: fd_per_1024 = 12;
            endcase
            repeat (5000) begin
                step($urandom_range(0, 599) == 0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 1023) < fd_per_1024);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/line_ring_ctrl.md
# line_ring_ctrl

Sequencer directly upstream of the 15-input line `mux`. Manages the pool of `LINES` line buffers as a ring: it hands free buffers to the Mandelbrot fill engine, counts completed lines, and drives the mux `select` and buffer read address in step with VGA line and pixel strobes. It flags underrun when the display needs a line that has not been filled.

## Interface
Parameters:
- `SELECT_WIDTH`, 4: width of buffer index (mux select).
- `LINES`, 15: number of line buffers; legal range 2..2^SELECT_WIDTH-1.
- `ADDR_WIDTH`, 10: pixel address width into a line buffer.
- `H_ACTIVE`, 640: active pixels per line.

Ports (one clock; reset is asynchronous, active-high):
- `clk` in 1: system clock.
- `reset` in 1: async active-high reset.
- `i_line_start` in 1: one-cycle pulse, start of an active VGA line.
- `i_pixel_en` in 1: active-pixel strobe, one read per asserted cycle.
- `i_fill_done` in 1: one-cycle pulse, the fill engine has finished buffer `o_fill_sel`.
- `o_fill_req` out 1: a free buffer is available to fill.
- `o_fill_sel` out SELECT_WIDTH: index of the buffer to fill.
- `o_select` out SELECT_WIDTH: buffer index to the mux `select`.
- `o_rd_addr` out ADDR_WIDTH: read pixel address into all line buffers.
- `o_underrun` out 1: sticky underrun flag.

## Operation
- State registers:
  - `fill_ptr` and `disp_ptr` count 0..LINES-1 and wrap from LINES-1 to 0.
  - `count` holds 0..LINES and is the number of filled lines not yet displayed.
- Fill side:
  - `o_fill_req = (count < LINES)`.
  - `o_fill_sel = fill_ptr`.
  - `i_fill_done` with `count < LINES`: `fill_ptr` advances and `count` increments.
  - `i_fill_done` with `count == LINES`: ignored.
- Display FSM has two states, IDLE and ACTIVE.
- IDLE, on `i_line_start`:
  - `count > 0`: `o_select <= disp_ptr`, `o_rd_addr <= 0`, go to ACTIVE with `own = 1`.
  - `count == 0`: set `o_underrun`, keep `o_select` (the previous line repeats), `o_rd_addr <= 0`, go to ACTIVE with `own = 0`.
- ACTIVE:
  - On each `i_pixel_en`, `o_rd_addr` increments.
  - On `i_pixel_en` with `o_rd_addr == H_ACTIVE-1`: address stays at H_ACTIVE-1 and the FSM returns to IDLE.
  - If `own`, that same cycle releases the buffer: `disp_ptr` advances and `count` decrements.
- `i_line_start` while in ACTIVE: the current line aborts without release, then the IDLE rule applies in the same cycle.
- Same-cycle fill-done and release: `count` is unchanged and both pointers advance.
- `o_underrun` clears only on reset.
- Width rules:
  - `count` is SELECT_WIDTH+1 bits.
  - All comparisons are unsigned.
  - `ADDR_WIDTH` must satisfy 2^ADDR_WIDTH ≥ H_ACTIVE.

## Timing
- Reset values:
  - All pointers, `count`, `o_select`, `o_rd_addr` and `o_underrun` are 0.
  - FSM in IDLE.
  - `o_fill_req = 1`, since it is combinational from `count = 0`.
  - `o_fill_sel = 0`.
- `o_select` and `o_rd_addr` are registered and become valid the cycle after `i_line_start`.
- Read address progression: the first `i_pixel_en` after that cycle reads address 0, then 1, and so on.
- `o_fill_req` and `o_fill_sel` are combinational from registers. They update the cycle after `i_fill_done` or a release.
- `count` changes take effect the cycle after the event, so underrun is evaluated on the registered `count`.
- Reset mid-line: everything returns to its reset value immediately (asynchronous). All filled lines are discarded.

## Structure
- Shared package holds `LINES`, `H_ACTIVE` and the display FSM state enum (IDLE/ACTIVE). The mux select width and the fill engine use the same constants.
- One sub-module: `ring_ptr` (mod-`LINES` wrapping counter with enable), instantiated twice for `fill_ptr` and `disp_ptr`.
- Everything else stays flat in `line_ring_ctrl`.

## Test plan
- Reset, then 3 `i_fill_done` pulses:
  - `o_fill_sel` steps 0→1→2→3.
  - `count = 3`, `o_fill_req = 1`, `o_underrun = 0`.
- With `count = 3`, a line start followed by 640 `i_pixel_en`:
  - `o_select = 0`.
  - `o_rd_addr` runs 0..639 and holds at 639.
  - `count = 2`, `disp_ptr = 1`.
- 15 fills with no display:
  - `o_fill_req` drops to 0.
  - A 16th `i_fill_done` is ignored; `fill_ptr` stays 0 after wrap.
- Line start with `count = 0`:
  - `o_underrun` goes to 1 and stays 1.
  - `o_select` holds its previous value; `count` stays 0 at line end.
- `i_fill_done` coincident with the last pixel (`o_rd_addr = 639`): `count` unchanged, both pointers advance.
- Assert `reset` at pixel 300: all outputs are 0 immediately and `o_fill_req = 1` once reset is released.
